serv_rf_ram_bridge: RTL and testbench
=====================================

# serv_rf_ram_bridge

Sequential bridge between the bit-serial register-file ports of the core and a simple dual-port synchronous RAM of configurable data width. It deserialises two write streams into RAM words, prefetches and serialises two read streams, and handles word addressing for GPRs plus CSR slots. It sits between `serv_rf_if` and the RF RAM macro.

## Interface
Parameters:
- `W`, 1: serial beat width in bits; allowed values are 1, 2, 4.
- `WIDTH`, 8: RAM data width; a power of two, `WIDTH % W == 0`, `WIDTH/W >= 2`, `WIDTH <= 32`.
- `WITH_CSR`, 1: adds 4 CSR slots (registers 32..35); register index width is `RW = 5+WITH_CSR`.
- `DEPTH`, `(32+4*WITH_CSR)*32/WIDTH`: RAM words.
- `AW`, `$clog2(DEPTH)`: RAM address width.

Ports:
- `i_clk` in 1: clock; all logic uses the rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_wreq` in 1: starts a write stream.
- `i_wreg0`, `i_wreg1` in RW: write register indices, sampled at `i_wreq`.
- `i_wen0`, `i_wen1` in 1: per-beat write enables.
- `i_wdata0`, `i_wdata1` in W: write beats, LSB first.
- `i_rreq` in 1: starts a read stream.
- `i_rreg0`, `i_rreg1` in RW: read register indices, sampled at `i_rreq`.
- `o_ready` out 1: one-cycle pulse; read beats follow.
- `o_rdata0`, `o_rdata1` out W: read beats, LSB first.
- `o_waddr` out AW, `o_wdata` out WIDTH, `o_wen` out 1: RAM write port.
- `o_raddr` out AW, `o_ren` out 1: RAM read port.
- `i_rdata` in WIDTH: RAM read data, valid 1 cycle after `o_ren`.

## Operation
- Word address = `reg*(32/WIDTH) + k`, where k is the word index (bits `k*WIDTH .. k*WIDTH+WIDTH-1`).
- Write path:
  - `i_wreq` latches the two write indices. Beats start the next cycle and run 32/W contiguous cycles.
  - Each port shifts its beats into a WIDTH-bit buffer.
  - A word for port N is written only if `i_wenN` was high on that word's last beat.
  - Port 0's word is written the cycle after the last beat; port 1's word the cycle after that.
  - The write engine is busy from `i_wreq` until the final port-1 write slot. `i_wreq` while busy is ignored.
- Read path:
  - `i_rreq` latches the two read indices.
  - RAM reads alternate: reg0 word k, then reg1 word k. Data lands in two WIDTH-bit shift buffers.
  - Word k+1 is prefetched while word k is shifted out.
  - Beats are contiguous for 32/W cycles with no gaps.
  - `i_rreq` while a read is busy is ignored.
- Read and write engines are independent and may overlap.
- RAM is read-first on a same-address collision. No forwarding is done.

## Timing
- Reset values: all outputs are 0, counters are 0, both engines are idle. Assertion mid-stream aborts; no RAM write is issued after reset.
- Read sequence, with `i_rreq` at cycle 0:
  - `o_ren` at cycles 1 (reg0 w0) and 2 (reg1 w0).
  - `o_ready` is high at cycle 3.
  - Beat n appears at cycle 4+n, for n = 0..32/W-1.
  - `o_rdata*` return to 0 after the last beat.
- Write sequence, with `i_wreq` at cycle 0:
  - Beat n is sampled at cycle 1+n.
  - For word k, the last beat is at `t = (k+1)*WIDTH/W`. `o_wen` is asserted at t+1 (port 0) and t+2 (port 1).
- `o_wen`, `o_ren`, `o_ready` are single-cycle pulses and are registered.

## Configuration
- `SERV_RF_RAM_BRIDGE_ZERO_X0_EN` defined:
  - A read of register 0 streams zeros; its RAM read is still issued but the data is discarded.
  - A write to register 0 never asserts `o_wen`.
- Undefined: register 0 is an ordinary RAM location; x0 handling is done upstream.

## Test plan
Default configuration for all scenarios: W=1, WIDTH=8, WITH_CSR=1.
- Single-port write: `i_wreq` with `wreg0=3`, `wen0=1`, data 0xA5A50F0F; `wen1=0` → `o_wen` 4 times, `o_waddr` 12,13,14,15, `o_wdata` 0x0F,0x0F,0xA5,0xA5, at cycles 9, 17, 25, 33.
- Dual-port write into a CSR slot: `wreg0=5` with 0x12345678, `wreg1=33` with 0xFFFFFFFF → alternating writes: addr 20/132 with 0x78/0xFF, …, addr 23/135 with 0x12/0xFF.
- Read: after the writes above, `i_rreq` with `rreg0=3`, `rreg1=5` → `o_ready` at cycle 3. Beats 4..35 give 0xA5A50F0F on `o_rdata0` and 0x12345678 on `o_rdata1`, LSB first.
- Busy rejection: a second `i_rreq` at cycle 10 with different indices → ignored. Stream unchanged; no extra `o_ready`.
- Reset mid-stream: `i_rst` at write beat 12 → all outputs 0 immediately, no further `o_wen`. The next `i_wreq` is accepted normally.
- With `SERV_RF_RAM_BRIDGE_ZERO_X0_EN`: write 0xFFFFFFFF to reg 0 → no `o_wen`. Reading reg 0 yields all-zero beats even if RAM word 0 is preloaded with 0xFF.

Source files
------------

// File: rtl/serv_rf_ram_bridge.sv
// Bit-serial RF port <-> dual-port RF RAM bridge: deserialises two write streams, prefetches/serialises two read streams.
// Optional: define SERV_RF_RAM_BRIDGE_ZERO_X0_EN to force x0 reads to zero and suppress x0 writes.
module serv_rf_ram_bridge #(
  parameter int W        = 1,
  parameter int WIDTH    = 8,
  parameter int WITH_CSR = 1,
  parameter int DEPTH    = (32+4*WITH_CSR)*32/WIDTH,
  parameter int AW       = $clog2(DEPTH),
  localparam int RW      = 5+WITH_CSR
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wreq,
  input  logic [RW-1:0]    i_wreg0,
  input  logic [RW-1:0]    i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [W-1:0]     i_wdata0,
  input  logic [W-1:0]     i_wdata1,
  input  logic             i_rreq,
  input  logic [RW-1:0]    i_rreg0,
  input  logic [RW-1:0]    i_rreg1,
  output logic             o_ready,
  output logic [W-1:0]     o_rdata0,
  output logic [W-1:0]     o_rdata1,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata
);

  localparam int NBEATS = 32/W;
  localparam int BPW    = WIDTH/W;
  localparam int NW     = 32/WIDTH;
  localparam int CW     = $clog2(NBEATS+5);

`ifdef SERV_RF_RAM_BRIDGE_ZERO_X0_EN
  localparam bit ZERO_X0 = 1'b1;
`else
  localparam bit ZERO_X0 = 1'b0;
`endif

  function automatic logic [AW-1:0] word_addr(input logic [RW-1:0] r, input int k);
    word_addr = AW'(int'(r)*NW + k);
  endfunction

  // ---------------- write engine ----------------
  logic             wbusy;
  logic [CW-1:0]    wcnt;
  logic [RW-1:0]    wreg0_q, wreg1_q;
  logic [WIDTH-1:0] wbuf0, wbuf1, wnext0, wnext1;
  logic             p1_slot, p1_en;
  logic [AW-1:0]    p1_addr;
  logic [WIDTH-1:0] p1_data;
  logic             w_beat, w_last, wz0, wz1;
  int               wk;

  always_comb begin
    w_beat = wbusy && (int'(wcnt) < NBEATS);
    w_last = w_beat && ((int'(wcnt) % BPW) == BPW-1);
    wk     = int'(wcnt) / BPW;
    wnext0 = {i_wdata0, wbuf0[WIDTH-1:W]};
    wnext1 = {i_wdata1, wbuf1[WIDTH-1:W]};
    wz0    = ZERO_X0 && (wreg0_q == '0);
    wz1    = ZERO_X0 && (wreg1_q == '0);
  end

  // Port 0 word goes out on the edge that samples its last beat; port 1 is parked one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wbusy   <= 1'b0;
      wcnt    <= '0;
      wreg0_q <= '0;
      wreg1_q <= '0;
      wbuf0   <= '0;
      wbuf1   <= '0;
      p1_slot <= 1'b0;
      p1_en   <= 1'b0;
      p1_addr <= '0;
      p1_data <= '0;
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_wen   <= 1'b0;
      p1_slot <= 1'b0;
      if (!wbusy && i_wreq) begin
        wbusy   <= 1'b1;
        wcnt    <= '0;
        wreg0_q <= i_wreg0;
        wreg1_q <= i_wreg1;
      end else if (wbusy) begin
        if (w_beat) begin
          wbuf0 <= wnext0;
          wbuf1 <= wnext1;
          wcnt  <= wcnt + CW'(1);
        end else begin
          wbusy <= 1'b0;
        end
      end
      if (w_last) begin
        o_wen   <= i_wen0 && !wz0;
        o_waddr <= word_addr(wreg0_q, wk);
        o_wdata <= wnext0;
        p1_slot <= 1'b1;
        p1_en   <= i_wen1 && !wz1;
        p1_addr <= word_addr(wreg1_q, wk);
        p1_data <= wnext1;
      end else if (p1_slot) begin
        o_wen   <= p1_en;
        o_waddr <= p1_addr;
        o_wdata <= p1_data;
      end
    end
  end

  // ---------------- read engine ----------------
  logic             rbusy;
  logic [CW-1:0]    rcnt;
  logic [RW-1:0]    rreg0_q, rreg1_q;
  logic             rz0_q, rz1_q;
  logic [WIDTH-1:0] rhold, rbuf0, rbuf1;
  logic             r_ren0, r_ren1, r_hold, r_load, r_ready, r_done;
  int               rc, rk;

  // rcnt is the cycle number since the accepted request; word j is loaded at cycle 3+j*BPW.
  always_comb begin
    rc      = int'(rcnt);
    rk      = rc / BPW;
    r_ren0  = rbusy && (rc >= BPW) && (rc % BPW == 0) && (rk < NW);
    r_ren1  = rbusy && (rc % BPW == 1) && (rk < NW);
    r_hold  = rbusy && (rc >= 2) && ((rc-2) % BPW == 0) && ((rc-2)/BPW < NW);
    r_load  = rbusy && (rc >= 3) && ((rc-3) % BPW == 0) && ((rc-3)/BPW < NW);
    r_ready = rbusy && (rc == 2);
    r_done  = rbusy && (rc == 3+NBEATS);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rbusy   <= 1'b0;
      rcnt    <= '0;
      rreg0_q <= '0;
      rreg1_q <= '0;
      rz0_q   <= 1'b0;
      rz1_q   <= 1'b0;
      rhold   <= '0;
      rbuf0   <= '0;
      rbuf1   <= '0;
      o_ren   <= 1'b0;
      o_raddr <= '0;
      o_ready <= 1'b0;
    end else begin
      o_ren   <= 1'b0;
      o_ready <= r_ready;
      if (!rbusy && i_rreq) begin
        rbusy   <= 1'b1;
        rcnt    <= CW'(1);
        rreg0_q <= i_rreg0;
        rreg1_q <= i_rreg1;
        rz0_q   <= ZERO_X0 && (i_rreg0 == '0);
        rz1_q   <= ZERO_X0 && (i_rreg1 == '0);
        o_ren   <= 1'b1;
        o_raddr <= word_addr(i_rreg0, 0);
      end else if (rbusy) begin
        rcnt <= rcnt + CW'(1);
        if (r_done) rbusy <= 1'b0;
      end
      if (r_ren0) begin
        o_ren   <= 1'b1;
        o_raddr <= word_addr(rreg0_q, rk);
      end else if (r_ren1) begin
        o_ren   <= 1'b1;
        o_raddr <= word_addr(rreg1_q, rk);
      end
      if (r_hold) rhold <= i_rdata;
      // Zero-filled shift leaves the beat outputs at 0 once a stream drains.
      if (r_load) begin
        rbuf0 <= rz0_q ? '0 : rhold;
        rbuf1 <= rz1_q ? '0 : i_rdata;
      end else begin
        rbuf0 <= rbuf0 >> W;
        rbuf1 <= rbuf1 >> W;
      end
    end
  end

  assign o_rdata0 = rbuf0[W-1:0];
  assign o_rdata1 = rbuf1[W-1:0];

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// Self-checking bench for serv_rf_ram_bridge (W=1, WIDTH=8, WITH_CSR=1) with a RAM model and a per-register reference.
module tb_serv_rf_ram_bridge;
  localparam int W = 1, WIDTH = 8, WITH_CSR = 1, DEPTH = 144, AW = 8, RW = 6;
`ifdef SERV_RF_RAM_BRIDGE_ZERO_X0_EN
  localparam bit ZX = 1'b1;
`else
  localparam bit ZX = 1'b0;
`endif

  logic clk = 1'b0, i_rst = 1'b1;
  logic i_wreq = 0, i_wen0 = 0, i_wen1 = 0, i_rreq = 0;
  logic [RW-1:0] i_wreg0 = 0, i_wreg1 = 0, i_rreg0 = 0, i_rreg1 = 0;
  logic [W-1:0] i_wdata0 = 0, i_wdata1 = 0, o_rdata0, o_rdata1;
  logic o_ready, o_wen, o_ren;
  logic [AW-1:0] o_waddr, o_raddr;
  logic [WIDTH-1:0] o_wdata, ram_q = '0;

  serv_rf_ram_bridge #(.W(W), .WIDTH(WIDTH), .WITH_CSR(WITH_CSR)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_wreq(i_wreq), .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
    .i_wen0(i_wen0), .i_wen1(i_wen1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .i_rreq(i_rreq), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
    .o_ready(o_ready), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
    .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(ram_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first synchronous dual-port RAM
  logic [WIDTH-1:0] mem [DEPTH];
  logic mem_clr = 1'b1, pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [WIDTH-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (o_ren) ram_q <= mem[o_raddr];
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (o_wen) mem[o_waddr] <= o_wdata;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  typedef struct { int addr; int data; int t; } wev_t;
  wev_t wq[$];
  always @(negedge clk) if (o_wen) wq.push_back('{int'(o_waddr), int'(o_wdata), cyc});

  logic [31:0] model [36];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [RW-1:0] r);
    return (ZX && r == 0) ? 32'h0 : model[r];
  endfunction

  // en0/en1 are per-beat enable masks; a word lands only if its last beat was enabled.
  task automatic do_write(input logic [RW-1:0] r0, input logic [31:0] d0, input logic [31:0] en0,
                          input logic [RW-1:0] r1, input logic [31:0] d1, input logic [31:0] en1,
                          input int rst_at, input int rej_at);
    wev_t ex[$];
    int c0, n;
    for (int k = 0; k < 4; k++) begin
      if (en0[8*k+7] && !(ZX && r0 == 0) && (rst_at == 0 || 9+8*k < rst_at)) begin
        ex.push_back('{int'(r0)*4+k, int'(d0[8*k +: 8]), 9+8*k});
        model[r0][8*k +: 8] = d0[8*k +: 8];
      end
      if (en1[8*k+7] && !(ZX && r1 == 0) && (rst_at == 0 || 10+8*k < rst_at)) begin
        ex.push_back('{int'(r1)*4+k, int'(d1[8*k +: 8]), 10+8*k});
        model[r1][8*k +: 8] = d1[8*k +: 8];
      end
    end
    @(negedge clk);
    wq.delete();
    c0 = cyc;
    i_wreq = 1; i_wreg0 = r0; i_wreg1 = r1;
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk);
      i_wreq = (rel == rej_at);
      i_wreg0 = 6'd20; i_wreg1 = 6'd21;
      if (rel <= 32) begin
        i_wdata0 = d0[rel-1]; i_wen0 = en0[rel-1];
        i_wdata1 = d1[rel-1]; i_wen1 = en1[rel-1];
      end else begin
        i_wdata0 = 0; i_wen0 = 0; i_wdata1 = 0; i_wen1 = 0;
      end
      if (rel == rst_at) begin
        i_rst = 1;
        #1;
        chk("rst_outs", {o_wen, o_ren, o_ready, o_rdata0, o_rdata1, o_waddr, o_wdata, o_raddr}, 64'h0);
      end else if (rst_at != 0 && rel == rst_at+1) i_rst = 0;
    end
    chk("wr_count", wq.size(), ex.size());
    n = (wq.size() < ex.size()) ? wq.size() : ex.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr_data", {32'(wq[i].addr), 32'(wq[i].data)}, {32'(ex[i].addr), 32'(ex[i].data)});
      chk("wr_cycle", wq[i].t - c0, ex[i].t);
    end
  endtask

  task automatic do_read(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                         input logic [31:0] e0, input logic [31:0] e1, input int rej_at);
    logic [31:0] g0, g1;
    int c0, nrdy, rdy_rel, nren, a1, a2;
    logic tail;
    g0 = 0; g1 = 0; nrdy = 0; rdy_rel = -1; nren = 0; a1 = -1; a2 = -1; tail = 0;
    @(negedge clk);
    c0 = cyc;
    i_rreq = 1; i_rreg0 = r0; i_rreg1 = r1;
    for (int rel = 1; rel <= 37; rel++) begin
      @(negedge clk);
      i_rreq = (rel == rej_at);
      i_rreg0 = 6'd33; i_rreg1 = 6'd35;
      if (o_ready) begin nrdy++; rdy_rel = rel; end
      if (o_ren) begin
        nren++;
        if (rel == 1) a1 = int'(o_raddr);
        if (rel == 2) a2 = int'(o_raddr);
      end
      if (rel >= 4 && rel <= 35) begin g0[rel-4] = o_rdata0; g1[rel-4] = o_rdata1; end
      if (rel >= 36) tail = tail | o_rdata0 | o_rdata1;
    end
    chk("ready_count", nrdy, 1);
    chk("ready_cycle", rdy_rel, 3);
    chk("ren_count", nren, 8);
    chk("ren_addr0", a1, int'(r0)*4);
    chk("ren_addr1", a2, int'(r1)*4);
    chk("rdata0", g0, e0);
    chk("rdata1", g1, e1);
    chk("rdata_tail", tail, 1'b0);
  endtask

  typedef struct {
    logic [RW-1:0] wr0; logic [31:0] wd0; logic we0;
    logic [RW-1:0] wr1; logic [31:0] wd1; logic we1;
    logic [RW-1:0] rr0, rr1; logic [31:0] exp0, exp1;
    int wrej, rrej;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [RW-1:0] a, b, c, d;
    logic [31:0] x, y;
    tbl[0] = '{6'd3,  32'hA5A50F0F, 1'b1, 6'd7,  32'hDEADBEEF, 1'b0, 6'd3,  6'd7,  32'hA5A50F0F, 32'h00000000, 0, 0};
    tbl[1] = '{6'd5,  32'h12345678, 1'b1, 6'd33, 32'hFFFFFFFF, 1'b1, 6'd3,  6'd5,  32'hA5A50F0F, 32'h12345678, 0, 10};
    tbl[2] = '{6'd35, 32'h80000001, 1'b1, 6'd31, 32'h0000FFFF, 1'b1, 6'd33, 6'd35, 32'hFFFFFFFF, 32'h80000001, 15, 0};
    tbl[3] = '{6'd31, 32'h11111111, 1'b1, 6'd31, 32'h22222222, 1'b1, 6'd31, 6'd5,  32'h22222222, 32'h12345678, 0, 0};
    tbl[4] = '{6'd1,  32'h00000000, 1'b1, 6'd2,  32'hFFFFFFFF, 1'b0, 6'd1,  6'd31, 32'h00000000, 32'h22222222, 0, 0};
    for (int i = 0; i < 36; i++) model[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset_wen", o_wen, 1'b0);
    chk("reset_ren", o_ren, 1'b0);
    chk("reset_ready", o_ready, 1'b0);
    chk("reset_rdata", {o_rdata0, o_rdata1}, 2'b0);
    chk("reset_addrs", {o_waddr, o_wdata, o_raddr}, 24'h0);
    i_rst = 0; mem_clr = 0;

    for (int i = 0; i < 5; i++) begin
      do_write(tbl[i].wr0, tbl[i].wd0, {32{tbl[i].we0}}, tbl[i].wr1, tbl[i].wd1, {32{tbl[i].we1}}, 0, tbl[i].wrej);
      do_read(tbl[i].rr0, tbl[i].rr1, tbl[i].exp0, tbl[i].exp1, tbl[i].rrej);
    end

    // reset at beat 12: only word 0 of each port lands, then a fresh write is accepted
    do_write(6'd9, 32'h11223344, '1, 6'd10, 32'h55667788, '1, 13, 0);
    do_write(6'd9, 32'hCAFEBABE, '1, 6'd10, 32'h99999999, '0, 0, 0);
    do_read(6'd9, 6'd10, 32'hCAFEBABE, 32'h00000088, 0);

`ifdef SERV_RF_RAM_BRIDGE_ZERO_X0_EN
    do_write(6'd0, 32'hFFFFFFFF, '1, 6'd0, 32'hFFFFFFFF, '1, 0, 0);
    @(negedge clk); pre_en = 1; pre_addr = '0; pre_data = 8'hFF;
    @(negedge clk); pre_en = 0;
    do_read(6'd0, 6'd3, 32'h0, rd_model(6'd3), 0);
`endif

    for (int it = 0; it < 16; it++) begin
      a = 6'($urandom_range(0, 35)); b = 6'($urandom_range(0, 35));
      x = $urandom; y = $urandom;
      do_write(a, x, $urandom | $urandom, b, y, $urandom | $urandom, 0, 0);
      c = (it % 2 == 0) ? a : 6'($urandom_range(0, 35));
      d = (it % 3 == 0) ? b : 6'($urandom_range(0, 35));
      do_read(c, d, rd_model(c), rd_model(d), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
